// File: rtl/sram_req_arbiter_pkg.sv
// rtl/sram_req_arbiter_pkg.sv - FSM encodings and master ids shared by the sram request arbiter
package sram_req_arbiter_pkg;

  typedef enum logic [2:0] {
    ARB_IDLE   = 3'b001,
    ARB_GRANT0 = 3'b010,
    ARB_GRANT1 = 3'b100
  } arb_state_e;

  localparam logic ARB_ID_M0 = 1'b0;
  localparam logic ARB_ID_M1 = 1'b1;

endpackage

// File: rtl/sram_arb_id_fifo.sv
// rtl/sram_arb_id_fifo.sv - 1-bit outstanding master-id FIFO, responses popped in issue order
module sram_arb_id_fifo
  import sram_req_arbiter_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic aclk,
  input  logic aresetn,
  input  logic push_i,
  input  logic push_id_i,
  input  logic pop_i,
  output logic full_o,
  output logic empty_o,
  output logic head_o
);

  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [DEPTH-1:0] mem_q;
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      cnt_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (cnt_q == FULL_CNT);
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign head_o  = mem_q[rd_ptr_q];

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_id_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/sram_req_arbiter.sv
// rtl/sram_req_arbiter.sv - two-master sram-like request arbiter with in-order response routing
// SRAM_ARB_RR_EN selects round-robin conflict resolution; default is fixed priority to m1.
module sram_req_arbiter
  import sram_req_arbiter_pkg::*;
#(
  parameter int OT_DEPTH = 4,
  parameter int OT_AW    = 2
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        m0_req,
  input  logic        m0_wr,
  input  logic [1:0]  m0_size,
  input  logic [31:0] m0_addr,
  input  logic [3:0]  m0_wstrb,
  input  logic [31:0] m0_wdata,
  output logic        m0_addr_ok,
  output logic        m0_data_ok,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_wr,
  input  logic [1:0]  m1_size,
  input  logic [31:0] m1_addr,
  input  logic [3:0]  m1_wstrb,
  input  logic [31:0] m1_wdata,
  output logic        m1_addr_ok,
  output logic        m1_data_ok,
  output logic [31:0] m1_rdata,
  output logic        s_req,
  output logic        s_wr,
  output logic [1:0]  s_size,
  output logic [31:0] s_addr,
  output logic [3:0]  s_wstrb,
  output logic [31:0] s_wdata,
  input  logic        s_addr_ok,
  input  logic        s_data_ok,
  input  logic [31:0] s_rdata,
  output logic        ot_full
);

  arb_state_e state_q, state_d;
  logic       winner;
  logic       sel;
  logic       want;
  logic       accept;
  logic       pop;
  logic       fifo_empty;
  logic       head;

`ifdef SRAM_ARB_RR_EN
  logic last_grant_q;

  always_comb begin
    winner = m1_req ? ARB_ID_M1 : ARB_ID_M0;
    if (m0_req && m1_req) winner = ~last_grant_q;
  end

  always_ff @(posedge aclk) begin
    if (!aresetn)    last_grant_q <= ARB_ID_M1;
    else if (accept) last_grant_q <= sel;
  end
`else
  always_comb begin
    winner = m1_req ? ARB_ID_M1 : ARB_ID_M0;
  end
`endif

  // Once a master was offered and not accepted, the mux stays on it until accept or drop.
  always_comb begin
    sel  = winner;
    want = m0_req | m1_req;
    case (state_q)
      ARB_GRANT0: begin sel = ARB_ID_M0; want = m0_req; end
      ARB_GRANT1: begin sel = ARB_ID_M1; want = m1_req; end
      default:    ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE:   if (s_req && !s_addr_ok) state_d = sel ? ARB_GRANT1 : ARB_GRANT0;
      ARB_GRANT0: if (!m0_req || accept)   state_d = ARB_IDLE;
      ARB_GRANT1: if (!m1_req || accept)   state_d = ARB_IDLE;
      default:    state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) state_q <= ARB_IDLE;
    else          state_q <= state_d;
  end

  assign s_req   = want & ~ot_full;
  assign accept  = s_req & s_addr_ok;
  assign s_wr    = s_req & (sel ? m1_wr : m0_wr);
  assign s_size  = s_req ? (sel ? m1_size  : m0_size)  : 2'b00;
  assign s_addr  = s_req ? (sel ? m1_addr  : m0_addr)  : 32'h0;
  assign s_wstrb = s_req ? (sel ? m1_wstrb : m0_wstrb) : 4'h0;
  assign s_wdata = s_req ? (sel ? m1_wdata : m0_wdata) : 32'h0;

  assign m0_addr_ok = accept & (sel == ARB_ID_M0);
  assign m1_addr_ok = accept & (sel == ARB_ID_M1);

  // Responses with nothing outstanding are dropped rather than routed.
  assign pop        = s_data_ok & ~fifo_empty;
  assign m0_data_ok = pop & (head == ARB_ID_M0);
  assign m1_data_ok = pop & (head == ARB_ID_M1);
  assign m0_rdata   = m0_data_ok ? s_rdata : 32'h0;
  assign m1_rdata   = m1_data_ok ? s_rdata : 32'h0;

  sram_arb_id_fifo #(
    .DEPTH (OT_DEPTH),
    .AW    (OT_AW)
  ) u_id_fifo (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .push_i    (accept),
    .push_id_i (sel),
    .pop_i     (pop),
    .full_o    (ot_full),
    .empty_o   (fifo_empty),
    .head_o    (head)
  );

endmodule

// File: tb/tb_sram_req_arbiter.sv
// tb/tb_sram_req_arbiter.sv - self-checking bench for sram_req_arbiter
module tb_sram_req_arbiter;

  localparam int OT_DEPTH = 4;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        m0_req, m0_wr, m1_req, m1_wr;
  logic [1:0]  m0_size, m1_size;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic        m0_addr_ok, m0_data_ok, m1_addr_ok, m1_data_ok;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_req, s_wr;
  logic [1:0]  s_size;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [3:0]  s_wstrb;
  logic        s_addr_ok, s_data_ok;
  logic        ot_full;

  int checks   = 0;
  int failures = 0;

  always #5 aclk = ~aclk;

  sram_req_arbiter #(.OT_DEPTH(OT_DEPTH), .OT_AW(2)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .m0_req(m0_req), .m0_wr(m0_wr), .m0_size(m0_size), .m0_addr(m0_addr),
    .m0_wstrb(m0_wstrb), .m0_wdata(m0_wdata),
    .m0_addr_ok(m0_addr_ok), .m0_data_ok(m0_data_ok), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_wr(m1_wr), .m1_size(m1_size), .m1_addr(m1_addr),
    .m1_wstrb(m1_wstrb), .m1_wdata(m1_wdata),
    .m1_addr_ok(m1_addr_ok), .m1_data_ok(m1_data_ok), .m1_rdata(m1_rdata),
    .s_req(s_req), .s_wr(s_wr), .s_size(s_size), .s_addr(s_addr),
    .s_wstrb(s_wstrb), .s_wdata(s_wdata),
    .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok), .s_rdata(s_rdata),
    .ot_full(ot_full)
  );

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic clear_inputs();
    m0_req = 0; m0_wr = 0; m0_size = 0; m0_addr = 0; m0_wstrb = 0; m0_wdata = 0;
    m1_req = 0; m1_wr = 0; m1_size = 0; m1_addr = 0; m1_wstrb = 0; m1_wdata = 0;
    s_addr_ok = 0; s_data_ok = 0; s_rdata = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    aresetn = 0;
    tick();
    tick();
    aresetn = 1;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge aclk);
    checks++;
    if ({s_req, s_wr, s_size, s_addr, s_wstrb, s_wdata} !== '0) begin
      failures++; $display("FAIL reset_s_fields got s_req=%b s_addr=%h expected all 0", s_req, s_addr);
    end
    checks++;
    if ({m0_addr_ok, m0_data_ok, m0_rdata, m1_addr_ok, m1_data_ok, m1_rdata, ot_full} !== '0) begin
      failures++; $display("FAIL reset_m_outputs got aok=%b%b dok=%b%b full=%b expected 0",
                           m0_addr_ok, m1_addr_ok, m0_data_ok, m1_data_ok, ot_full);
    end
    tick();
  endtask

  task automatic test_single_read();
    do_reset();
    m0_req = 1; m0_addr = 32'h1c00_0000; m0_size = 2; s_addr_ok = 1;
    @(negedge aclk);
    checks++;
    if (m0_addr_ok !== 1'b1 || s_addr !== 32'h1c00_0000 || m1_addr_ok !== 1'b0) begin
      failures++; $display("FAIL single_accept got m0_aok=%b s_addr=%h m1_aok=%b expected 1 1c000000 0",
                           m0_addr_ok, s_addr, m1_addr_ok);
    end
    tick();
    m0_req = 0; s_addr_ok = 0;
    tick();
    s_data_ok = 1; s_rdata = 32'h1234_5678;
    @(negedge aclk);
    checks++;
    if (m0_data_ok !== 1'b1 || m0_rdata !== 32'h1234_5678) begin
      failures++; $display("FAIL single_data got m0_dok=%b rdata=%h expected 1 12345678", m0_data_ok, m0_rdata);
    end
    checks++;
    if ({m1_addr_ok, m1_data_ok, m1_rdata} !== '0) begin
      failures++; $display("FAIL single_m1_quiet got m1_dok=%b m1_rdata=%h expected 0 0", m1_data_ok, m1_rdata);
    end
    tick();
    s_data_ok = 0;
  endtask

  task automatic test_conflict();
    int first;
    do_reset();
`ifdef SRAM_ARB_RR_EN
    first = 0;
`else
    first = 1;
`endif
    m0_req = 1; m0_addr = 32'h0000_1000; m1_req = 1; m1_addr = 32'h0000_2000; s_addr_ok = 1;
    @(negedge aclk);
    checks++;
    if ({m1_addr_ok, m0_addr_ok} !== ((first == 1) ? 2'b10 : 2'b01)) begin
      failures++; $display("FAIL conflict_first got m1m0_aok=%b%b expected winner m%0d", m1_addr_ok, m0_addr_ok, first);
    end
    tick();
    if (first == 1) m1_req = 0; else m0_req = 0;
    @(negedge aclk);
    checks++;
    if ({m1_addr_ok, m0_addr_ok} !== ((first == 1) ? 2'b01 : 2'b10)) begin
      failures++; $display("FAIL conflict_second got m1m0_aok=%b%b expected m%0d", m1_addr_ok, m0_addr_ok, 1 - first);
    end
    tick();
    m0_req = 0; m1_req = 0; s_addr_ok = 0; s_data_ok = 1;
    @(negedge aclk);
    checks++;
    if ({m1_data_ok, m0_data_ok} !== ((first == 1) ? 2'b10 : 2'b01)) begin
      failures++; $display("FAIL conflict_dok_first got m1m0_dok=%b%b expected m%0d", m1_data_ok, m0_data_ok, first);
    end
    tick();
    @(negedge aclk);
    checks++;
    if ({m1_data_ok, m0_data_ok} !== ((first == 1) ? 2'b01 : 2'b10)) begin
      failures++; $display("FAIL conflict_dok_second got m1m0_dok=%b%b expected m%0d", m1_data_ok, m0_data_ok, 1 - first);
    end
    tick();
    s_data_ok = 0;
  endtask

  task automatic test_grant_lock();
    do_reset();
    m0_req = 1; m0_addr = 32'hA000_0000; s_addr_ok = 0;
    tick();
    m1_req = 1; m1_addr = 32'hB000_0000;
    for (int i = 0; i < 3; i++) begin
      @(negedge aclk);
      checks++;
      if (s_addr !== 32'hA000_0000 || m1_addr_ok !== 1'b0 || s_req !== 1'b1) begin
        failures++; $display("FAIL lock_hold[%0d] got s_addr=%h s_req=%b expected a0000000 1", i, s_addr, s_req);
      end
      tick();
    end
    s_addr_ok = 1;
    @(negedge aclk);
    checks++;
    if (m0_addr_ok !== 1'b1 || m1_addr_ok !== 1'b0) begin
      failures++; $display("FAIL lock_accept got m0_aok=%b m1_aok=%b expected 1 0", m0_addr_ok, m1_addr_ok);
    end
    tick();
    m0_req = 0;
    @(negedge aclk);
    checks++;
    if (m1_addr_ok !== 1'b1 || s_addr !== 32'hB000_0000) begin
      failures++; $display("FAIL lock_next got m1_aok=%b s_addr=%h expected 1 b0000000", m1_addr_ok, s_addr);
    end
    tick();
    m1_req = 0; s_addr_ok = 0;
  endtask

  task automatic test_ot_full();
    do_reset();
    m1_req = 1; m1_addr = 32'h0000_0040; s_addr_ok = 1;
    for (int i = 0; i < OT_DEPTH; i++) begin
      @(negedge aclk);
      checks++;
      if (m1_addr_ok !== 1'b1 || ot_full !== 1'b0) begin
        failures++; $display("FAIL full_fill[%0d] got aok=%b full=%b expected 1 0", i, m1_addr_ok, ot_full);
      end
      tick();
    end
    @(negedge aclk);
    checks++;
    if (ot_full !== 1'b1 || m1_addr_ok !== 1'b0 || s_req !== 1'b0) begin
      failures++; $display("FAIL full_block got full=%b aok=%b s_req=%b expected 1 0 0", ot_full, m1_addr_ok, s_req);
    end
    tick();
    s_data_ok = 1;
    @(negedge aclk);
    checks++;
    if (m1_addr_ok !== 1'b0 || m1_data_ok !== 1'b1 || s_req !== 1'b0) begin
      failures++; $display("FAIL full_pop_same got aok=%b dok=%b s_req=%b expected 0 1 0", m1_addr_ok, m1_data_ok, s_req);
    end
    tick();
    s_data_ok = 0;
    @(negedge aclk);
    checks++;
    if (ot_full !== 1'b0 || m1_addr_ok !== 1'b1) begin
      failures++; $display("FAIL full_resume got full=%b aok=%b expected 0 1", ot_full, m1_addr_ok);
    end
    tick();
    m1_req = 0; s_addr_ok = 0;
  endtask

  task automatic test_reset_flush();
    do_reset();
    m0_req = 1; m1_req = 1; s_addr_ok = 1;
    tick();
    tick();
    m0_req = 0; m1_req = 0; s_addr_ok = 0;
    aresetn = 0;
    tick();
    aresetn = 1;
    s_data_ok = 1; s_rdata = 32'hDEAD_BEEF;
    @(negedge aclk);
    checks++;
    if ({m0_data_ok, m1_data_ok, m0_rdata, m1_rdata, ot_full} !== '0) begin
      failures++; $display("FAIL flush_stale got dok=%b%b full=%b expected 0 0 0", m0_data_ok, m1_data_ok, ot_full);
    end
    tick();
    s_data_ok = 0;
  endtask

  // Reference: queue of issued master ids; "offered" is the master shown to the slave
  // last cycle and not yet accepted, which the slave keeps seeing until accept or drop.
  task automatic test_random();
    int q[$];
    int offered;
    int last;
    int cand;
    bit full;
    bit e_req;
    bit e_aok0, e_aok1, e_dok0, e_dok1;
    logic [31:0] e_addr;
    logic [3:0]  e_wstrb;
    bit          e_wr;
    bit          acc0, acc1;
    do_reset();
    offered = -1;
    last    = 1;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge aclk);
      full = (q.size() == OT_DEPTH);
      if (offered >= 0) begin
        cand = ((offered == 0) ? m0_req : m1_req) ? offered : -1;
      end else if (m0_req && m1_req) begin
`ifdef SRAM_ARB_RR_EN
        cand = 1 - last;
`else
        cand = 1;
`endif
      end else if (m1_req) cand = 1;
      else if (m0_req)     cand = 0;
      else                 cand = -1;
      e_req   = (cand >= 0) && !full;
      e_addr  = !e_req ? 32'h0 : (cand == 1 ? m1_addr  : m0_addr);
      e_wstrb = !e_req ? 4'h0  : (cand == 1 ? m1_wstrb : m0_wstrb);
      e_wr    = e_req && (cand == 1 ? m1_wr : m0_wr);
      e_aok0  = e_req && s_addr_ok && cand == 0;
      e_aok1  = e_req && s_addr_ok && cand == 1;
      e_dok0  = s_data_ok && q.size() > 0 && q[0] == 0;
      e_dok1  = s_data_ok && q.size() > 0 && q[0] == 1;
      checks++;
      if (s_req !== e_req || s_addr !== e_addr || s_wstrb !== e_wstrb || s_wr !== e_wr) begin
        failures++; $display("FAIL rand_s_bus cyc%0d got req=%b addr=%h wr=%b expected req=%b addr=%h wr=%b",
                             cyc, s_req, s_addr, s_wr, e_req, e_addr, e_wr);
      end
      checks++;
      if (m0_addr_ok !== e_aok0 || m1_addr_ok !== e_aok1 || ot_full !== full) begin
        failures++; $display("FAIL rand_addr_ok cyc%0d got aok=%b%b full=%b expected aok=%b%b full=%b",
                             cyc, m0_addr_ok, m1_addr_ok, ot_full, e_aok0, e_aok1, full);
      end
      checks++;
      if (m0_data_ok !== e_dok0 || m1_data_ok !== e_dok1 ||
          m0_rdata !== (e_dok0 ? s_rdata : 32'h0) || m1_rdata !== (e_dok1 ? s_rdata : 32'h0)) begin
        failures++; $display("FAIL rand_data_ok cyc%0d got dok=%b%b expected dok=%b%b",
                             cyc, m0_data_ok, m1_data_ok, e_dok0, e_dok1);
      end
      acc0 = m0_addr_ok;
      acc1 = m1_addr_ok;
      if (s_data_ok && q.size() > 0) void'(q.pop_front());
      if (e_req && s_addr_ok) begin
        q.push_back(cand);
        last    = cand;
        offered = -1;
      end else if (e_req) begin
        offered = cand;
      end else if (offered >= 0 && cand < 0) begin
        offered = -1;
      end
      tick();
      if (acc0) m0_req = 0;
      if (acc1) m1_req = 0;
      if (!m0_req && $urandom_range(2, 0) == 0) begin
        m0_req = 1; m0_addr = $urandom; m0_wr = $urandom_range(1, 0); m0_wstrb = $urandom_range(15, 0);
        m0_size = $urandom_range(2, 0); m0_wdata = $urandom;
      end
      if (!m1_req && $urandom_range(2, 0) == 0) begin
        m1_req = 1; m1_addr = $urandom; m1_wr = $urandom_range(1, 0); m1_wstrb = $urandom_range(15, 0);
        m1_size = $urandom_range(2, 0); m1_wdata = $urandom;
      end
      s_addr_ok = $urandom_range(1, 0);
      s_data_ok = (q.size() > 0) && ($urandom_range(2, 0) != 0);
      s_rdata   = $urandom;
    end
    clear_inputs();
  endtask

  initial begin
    aresetn = 0;
    clear_inputs();
    test_reset();
    test_single_read();
    test_conflict();
    test_grant_lock();
    test_ot_full();
    test_reset_flush();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
